// File: rtl/sha3_pkg.sv
// Shared constants and state encoding for the SHA3-512 absorb sequencer.
package sha3_pkg;

    localparam int WORD_W     = 16;
    localparam int RATE_WORDS = 36;
    localparam int LEN_W      = 16;
    localparam int RATE_BITS  = 576;

    localparam logic [15:0] PAD_FIRST = 16'h0600;
    localparam logic [15:0] PAD_LAST  = 16'h0080;

    typedef enum logic [2:0] {
        IDLE,
        FILL,
        PAD,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/sha3_pad_word.sv
// Combinational pad10*1 mask generator: which words survive and what gets OR-ed in,
// given the index of the first word after the message data.
module sha3_pad_word #(
    parameter int WORD_W     = sha3_pkg::WORD_W,
    parameter int RATE_WORDS = sha3_pkg::RATE_WORDS,
    parameter int IDX_W      = 6
) (
    input  logic [IDX_W-1:0]             word_idx,
    output logic [WORD_W*RATE_WORDS-1:0] keep_mask,
    output logic [WORD_W*RATE_WORDS-1:0] pad_bits
);
    import sha3_pkg::*;

    localparam int BLK_W = WORD_W * RATE_WORDS;

    genvar gi;
    generate
        for (gi = 0; gi < RATE_WORDS; gi++) begin : g_word
            logic             keep;
            logic [WORD_W-1:0] first_bits;
            logic [WORD_W-1:0] last_bits;

            // Words below word_idx carry message data; everything from word_idx up is rebuilt.
            assign keep       = (IDX_W'(gi) < word_idx);
            assign first_bits = (IDX_W'(gi) == word_idx) ? WORD_W'(PAD_FIRST) : '0;
            assign last_bits  = (gi == RATE_WORDS - 1) ? WORD_W'(PAD_LAST) : '0;

            assign keep_mask[BLK_W-1-gi*WORD_W -: WORD_W] = {WORD_W{keep}};
            assign pad_bits[BLK_W-1-gi*WORD_W -: WORD_W]  = first_bits | last_bits;
        end
    endgenerate

endmodule

// File: rtl/sha3_absorb_ctrl.sv
// Absorb sequencer: drains FIFO words into 576-bit rate blocks, applies pad10*1
// and offers each block to the Keccak core over valid/ready.
module sha3_absorb_ctrl #(
    parameter int WORD_W     = sha3_pkg::WORD_W,
    parameter int RATE_WORDS = sha3_pkg::RATE_WORDS,
    parameter int LEN_W      = sha3_pkg::LEN_W
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [LEN_W-1:0]             msg_len,
    input  logic                         fifo_empty,
    input  logic [WORD_W-1:0]            fifo_data,
    output logic                         fifo_rd,
    output logic [WORD_W*RATE_WORDS-1:0] blk_data,
    output logic                         blk_valid,
    input  logic                         blk_ready,
    output logic                         blk_last,
    output logic                         busy,
    output logic                         done
);
    import sha3_pkg::*;

    localparam int               BLK_W    = WORD_W * RATE_WORDS;
    localparam int               IDX_W    = 6;
    localparam logic [IDX_W-1:0] RATE_CNT = IDX_W'(RATE_WORDS);

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   remaining_reg, remaining_next;
    logic [IDX_W-1:0]   word_idx_reg, word_idx_next;
    logic [IDX_W-1:0]   issued_reg, issued_next;
    logic               rd_q_reg, rd_q_next;
    logic [BLK_W-1:0]   blk_data_reg, blk_data_next;
    logic               blk_last_reg, blk_last_next;

    logic               want_rd;
    logic [BLK_W-1:0]   keep_mask;
    logic [BLK_W-1:0]   pad_bits;

    sha3_pad_word #(
        .WORD_W     (WORD_W),
        .RATE_WORDS (RATE_WORDS),
        .IDX_W      (IDX_W)
    ) u_pad (
        .word_idx  (word_idx_reg),
        .keep_mask (keep_mask),
        .pad_bits  (pad_bits)
    );

    // remaining only shrinks when a block's fill completes, so issued_reg is
    // compared against the words still owed to the message, capped at one block.
    assign want_rd = (LEN_W'(issued_reg) < remaining_reg) && (issued_reg < RATE_CNT);

    always_comb begin
        state_next     = state_reg;
        remaining_next = remaining_reg;
        word_idx_next  = word_idx_reg;
        issued_next    = issued_reg;
        rd_q_next      = 1'b0;
        blk_data_next  = blk_data_reg;
        blk_last_next  = blk_last_reg;
        fifo_rd        = 1'b0;
        blk_valid      = 1'b0;
        busy           = 1'b0;
        done           = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start) begin
                    remaining_next = msg_len;
                    word_idx_next  = '0;
                    issued_next    = '0;
                    blk_data_next  = '0;
                    blk_last_next  = 1'b0;
                    state_next     = FILL;
                end
            end

            FILL: begin
                busy      = 1'b1;
                fifo_rd   = want_rd && !fifo_empty;
                rd_q_next = fifo_rd;
                if (fifo_rd) begin
                    issued_next = issued_reg + 1'b1;
                end
                // FIFO data lands one cycle after the strobe.
                if (rd_q_reg) begin
                    for (int i = 0; i < RATE_WORDS; i++) begin
                        if (word_idx_reg == IDX_W'(i)) begin
                            blk_data_next[BLK_W-1-i*WORD_W -: WORD_W] = fifo_data;
                        end
                    end
                    word_idx_next = word_idx_reg + 1'b1;
                end
                if (!want_rd && !rd_q_reg) begin
                    remaining_next = remaining_reg - LEN_W'(word_idx_reg);
                    state_next     = (word_idx_reg == RATE_CNT) ? EMIT : PAD;
                end
            end

            PAD: begin
                busy          = 1'b1;
                blk_data_next = (blk_data_reg & keep_mask) | pad_bits;
                blk_last_next = 1'b1;
                state_next    = EMIT;
            end

            EMIT: begin
                busy      = 1'b1;
                blk_valid = 1'b1;
                if (blk_ready) begin
                    if (blk_last_reg) begin
                        state_next = DONE;
                    end else begin
                        // A full block with nothing left still owes a pad-only block.
                        word_idx_next = '0;
                        issued_next   = '0;
                        blk_data_next = '0;
                        state_next    = (remaining_reg == '0) ? PAD : FILL;
                    end
                end
            end

            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            remaining_reg <= '0;
            word_idx_reg  <= '0;
            issued_reg    <= '0;
            rd_q_reg      <= 1'b0;
            blk_data_reg  <= '0;
            blk_last_reg  <= 1'b0;
        end else begin
            state_reg     <= state_next;
            remaining_reg <= remaining_next;
            word_idx_reg  <= word_idx_next;
            issued_reg    <= issued_next;
            rd_q_reg      <= rd_q_next;
            blk_data_reg  <= blk_data_next;
            blk_last_reg  <= blk_last_next;
        end
    end

    assign blk_data = blk_data_reg;
    assign blk_last = blk_last_reg;

endmodule
